// File: rtl/seven_segment_capture.sv
// Loopback monitor for a multiplexed 7-segment bus: sync, debounce, decode, reassemble 4 digits.
// Optional SEVEN_SEG_CAPTURE_STATS_EN adds frame_cnt / err_cnt outputs.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int STAB_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  grounds_in,
  input  logic [6:0]  segs_in,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        seg_err,
  output logic        grounds_err
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  typedef struct packed {
    logic [3:0] grounds;
    logic [6:0] segs;
  } sample_t;

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  sample_t           sync1, s, s_prev;
  logic [STAB_W-1:0] stab_cnt;
  logic [3:0][3:0]   digit_q, digit_nx;
  logic [3:0]        mask_q, mask_nx;
  logic              accept, blank, one_hot, dec_ok;
  logic [1:0]        idx;
  logic [3:0]        nib;

  function automatic logic [4:0] decode(input logic [6:0] sg);
    case (sg)
      7'b1111110: decode = {1'b1, 4'h0};
      7'b0110000: decode = {1'b1, 4'h1};
      7'b1101101: decode = {1'b1, 4'h2};
      7'b1111001: decode = {1'b1, 4'h3};
      7'b0110011: decode = {1'b1, 4'h4};
      7'b1011011: decode = {1'b1, 4'h5};
      7'b1011111: decode = {1'b1, 4'h6};
      7'b1110000: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1111011: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b0011111: decode = {1'b1, 4'hB};
      7'b1001110: decode = {1'b1, 4'hC};
      7'b0111101: decode = {1'b1, 4'hD};
      7'b1001111: decode = {1'b1, 4'hE};
      7'b1000111: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  // Counter saturates at STAB_MAX, so the accept compare matches once per stable interval.
  assign accept = (s == s_prev) && (stab_cnt == STAB_MAX - 1'b1);
  assign blank  = (s.grounds == 4'b1111);
  assign {dec_ok, nib} = decode(s.segs);

  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (s.grounds)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // A repeat of an already-captured digit restarts the frame at that digit.
  always_comb begin
    digit_nx      = digit_q;
    digit_nx[idx] = nib;
    mask_nx       = mask_q[idx] ? (4'b0001 << idx) : (mask_q | (4'b0001 << idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      s           <= '0;
      s_prev      <= '0;
      stab_cnt    <= '0;
      digit_q     <= '0;
      mask_q      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      grounds_err <= 1'b0;
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
      frame_cnt   <= '0;
      err_cnt     <= '0;
`endif
    end else begin
      sync1       <= {grounds_in, segs_in};
      s           <= sync1;
      s_prev      <= s;
      value_valid <= 1'b0;
      seg_err     <= 1'b0;
      grounds_err <= 1'b0;
      if (s != s_prev)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;

      if (accept && !blank) begin
        if (!one_hot) begin
          grounds_err <= 1'b1;
          mask_q      <= '0;
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
        end else if (!dec_ok) begin
          seg_err <= 1'b1;
          mask_q  <= '0;
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
        end else begin
          digit_q <= digit_nx;
          if (mask_nx == 4'hF) begin
            value       <= digit_nx;
            value_valid <= 1'b1;
            mask_q      <= '0;
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
            frame_cnt   <= frame_cnt + 16'd1;
`endif
          end else begin
            mask_q <= mask_nx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture (STABLE_CYCLES=4): vector table plus hand sequences,
// expected pulses queued at drive time and matched by a negedge monitor.
module tb_seven_segment_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  grounds_in;
  logic [6:0]  segs_in;
  logic [15:0] value;
  logic        value_valid, seg_err, grounds_err;
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  seven_segment_capture #(.STABLE_CYCLES(4), .STAB_W(8)) dut (
    .clk(clk), .rst(rst), .grounds_in(grounds_in), .segs_in(segs_in),
    .value(value), .value_valid(value_valid), .seg_err(seg_err), .grounds_err(grounds_err)
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam int NONE = 0, VAL = 1, SEG = 2, GND = 3;

  typedef struct {int kind; logic [15:0] v;} ev_t;
  typedef struct {logic [3:0] g; logic [6:0] s; int n; int kind; logic [15:0] v;} vec_t;

  ev_t        q[$];
  vec_t       tbl[$];
  logic [6:0] segtab [16];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic got(input int k, input logic [15:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d value %h, expected no pulse", k, v);
    end else begin
      e = q.pop_front();
      if (e.kind != k || (k == VAL && e.v !== v)) begin
        errors++;
        $display("FAIL pulse_match: got kind %0d value %h, expected kind %0d value %h", k, v, e.kind, e.v);
      end
    end
  endtask

  task automatic drain(input string nm);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulses missing, expected 0", nm, q.size());
    end
    q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (value_valid) got(VAL, value);
      if (seg_err)     got(SEG, 16'h0);
      if (grounds_err) got(GND, 16'h0);
    end
  end

  function automatic vec_t dg(input int d, input int nb, input int kind = NONE, input logic [15:0] v = 16'h0);
    vec_t r;
    logic [3:0] one = 4'b0001;
    r.g = ~(one << d);
    r.s = segtab[nb];
    r.n = 10;
    r.kind = kind;
    r.v = v;
    return r;
  endfunction

  function automatic vec_t raw(input logic [3:0] g, input logic [6:0] s, input int kind = NONE);
    vec_t r;
    r.g = g; r.s = s; r.n = 10; r.kind = kind; r.v = 16'h0;
    return r;
  endfunction

  task automatic apply(input vec_t r);
    ev_t e;
    @(posedge clk); #1;
    if (r.kind != NONE) begin
      e.kind = r.kind; e.v = r.v;
      q.push_back(e);
    end
    grounds_in = r.g;
    segs_in    = r.s;
    repeat (r.n - 1) @(posedge clk);
  endtask

  initial begin
    vec_t h;
    segtab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
               7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    rst = 1'b1; grounds_in = 4'b1111; segs_in = 7'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_value", value, 16'h0);
    chk("reset_pulses", {13'b0, value_valid, seg_err, grounds_err}, 16'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // plain scan, full decode sweep, seg error, grounds error/blank, resync on repeat
    tbl.push_back(dg(0, 14)); tbl.push_back(dg(1, 15)); tbl.push_back(dg(2, 15));
    tbl.push_back(dg(3, 15, VAL, 16'hFFFE));
    for (int f = 0; f < 4; f++)
      for (int d = 0; d < 4; d++)
        tbl.push_back(dg(d, f*4 + d, d == 3 ? VAL : NONE,
                         {4'(f*4+3), 4'(f*4+2), 4'(f*4+1), 4'(f*4)}));
    tbl.push_back(dg(0, 1)); tbl.push_back(raw(4'b1101, 7'b0000001, SEG));
    tbl.push_back(dg(2, 2)); tbl.push_back(dg(3, 3)); tbl.push_back(dg(0, 4));
    tbl.push_back(dg(1, 5, VAL, 16'h3254));
    tbl.push_back(raw(4'b1100, segtab[8], GND)); tbl.push_back(raw(4'b1111, segtab[8]));
    tbl.push_back(dg(0, 10)); tbl.push_back(dg(1, 11)); tbl.push_back(raw(4'b1111, segtab[0]));
    tbl.push_back(dg(2, 12)); tbl.push_back(dg(3, 13, VAL, 16'hDCBA));
    tbl.push_back(dg(0, 1)); tbl.push_back(dg(1, 2)); tbl.push_back(dg(0, 3));
    tbl.push_back(dg(1, 4)); tbl.push_back(dg(2, 5)); tbl.push_back(dg(3, 6, VAL, 16'h6543));
    foreach (tbl[i]) apply(tbl[i]);
    repeat (3) @(posedge clk);
    drain("table_missing");
    #1 chk("value_hold", value, 16'h6543);

    // short 3-cycle digit must not be accepted nor touch the mask
    apply(dg(0, 9));
    h = dg(1, 8); h.n = 3; apply(h);
    apply(dg(2, 7)); apply(dg(3, 6));
    drain("short_pattern_no_pulse");
    apply(dg(1, 5, VAL, 16'h6759));
    repeat (3) @(posedge clk);
    drain("short_pattern_frame");

`ifdef SEVEN_SEG_CAPTURE_STATS_EN
    #1;
    chk("frame_cnt", frame_cnt, 16'd9);
    chk("err_cnt", {8'h0, err_cnt}, 16'd2);
`endif

    // reset mid-frame drops partial digits
    apply(dg(0, 1)); apply(dg(1, 2));
    apply(raw(4'b1111, segtab[0]));
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_value", value, 16'h0);
    chk("midrst_valid", {15'b0, value_valid}, 16'h0);
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
    chk("midrst_frame_cnt", frame_cnt, 16'h0);
    chk("midrst_err_cnt", {8'h0, err_cnt}, 16'h0);
`endif
    rst = 1'b0;
    repeat (10) @(posedge clk);
    apply(dg(2, 3)); apply(dg(3, 4));
    drain("post_rst_partial");
    apply(dg(0, 5)); apply(dg(1, 6, VAL, 16'h4365));
    repeat (3) @(posedge clk);
    drain("post_rst_frame");
    #1 chk("post_rst_value", value, 16'h4365);
`ifdef SEVEN_SEG_CAPTURE_STATS_EN
    chk("post_rst_frame_cnt", frame_cnt, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
